// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_gen
// Function : streaming 3x3 stride-1 sliding-window generator with two line
//            buffers, feeding 9 pixel lanes to the MAC core.
// Revision : 1.0
// ============================================================================
module conv_window_gen #(
    parameter int DATA_WIDTH    = 8,
    parameter int KERNEL_SIZE   = 3,
    parameter int MAX_IMG_WIDTH = 256,
    parameter int DIM_WIDTH     = 9
) (
    input  logic                                      clk,
    input  logic                                      rstn,
    input  logic [DIM_WIDTH-1:0]                      cfg_img_width,
    input  logic [DIM_WIDTH-1:0]                      cfg_img_height,
    input  logic                                      start,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      cfg_err,
    input  logic [DATA_WIDTH-1:0]                     pix_in,
    input  logic                                      pix_valid_in,
    output logic                                      pix_ready_out,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window_data_out,
    output logic                                      window_valid_out,
    output logic                                      window_last_out
);

    localparam int LANES      = KERNEL_SIZE * KERNEL_SIZE;
    localparam int ADDR_WIDTH = $clog2(MAX_IMG_WIDTH);
    localparam logic [DIM_WIDTH-1:0] MIN_DIM   = DIM_WIDTH'(KERNEL_SIZE);
    localparam logic [DIM_WIDTH-1:0] MAX_W     = DIM_WIDTH'(MAX_IMG_WIDTH);
    localparam logic [DIM_WIDTH-1:0] EDGE_SKIP = DIM_WIDTH'(KERNEL_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [DIM_WIDTH-1:0]  img_w, img_h, col, row;
    logic                  accept, cfg_ok, start_ok, col_last, frame_last, win_hit;
    logic [ADDR_WIDTH-1:0] addr;

    logic [DATA_WIDTH-1:0] lb0 [MAX_IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb1 [MAX_IMG_WIDTH];
    logic [DATA_WIDTH-1:0] tap  [KERNEL_SIZE];
    logic [DATA_WIDTH-1:0] hist [KERNEL_SIZE][KERNEL_SIZE-1];
    logic [LANES*DATA_WIDTH-1:0] win_next;

    assign busy          = (state == S_RUN);
    assign done          = (state == S_DONE);
    assign pix_ready_out = busy;
    assign accept        = pix_valid_in && busy;

    assign cfg_ok   = (cfg_img_width >= MIN_DIM) && (cfg_img_width <= MAX_W) &&
                      (cfg_img_height >= MIN_DIM);
    assign start_ok = (state == S_IDLE) && start && cfg_ok;

    assign col_last   = (col == img_w - DIM_WIDTH'(1));
    assign frame_last = col_last && (row == img_h - DIM_WIDTH'(1));
    assign win_hit    = (row >= EDGE_SKIP) && (col >= EDGE_SKIP);
    assign addr       = col[ADDR_WIDTH-1:0];

    // New right column: two lines up, one line up, current pixel.
    assign tap[0] = lb1[addr];
    assign tap[1] = lb0[addr];
    assign tap[2] = pix_in;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_ok) state_next = S_RUN;
            S_RUN:   if (accept && frame_last) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Line buffers carry no reset; stale contents are masked by row/col gating.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[addr] <= lb0[addr];
            lb0[addr] <= pix_in;
        end
    end

    always_comb begin
        win_next = '0;
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            for (int c = 0; c < KERNEL_SIZE - 1; c++)
                win_next[(r*KERNEL_SIZE + c)*DATA_WIDTH +: DATA_WIDTH] = hist[r][c];
            win_next[(r*KERNEL_SIZE + KERNEL_SIZE - 1)*DATA_WIDTH +: DATA_WIDTH] = tap[r];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < KERNEL_SIZE; r++)
                for (int c = 0; c < KERNEL_SIZE - 1; c++)
                    hist[r][c] <= '0;
        end else if (accept) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE - 2; c++)
                    hist[r][c] <= hist[r][c+1];
                hist[r][KERNEL_SIZE-2] <= tap[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            img_w            <= '0;
            img_h            <= '0;
            col              <= '0;
            row              <= '0;
            cfg_err          <= 1'b0;
            window_valid_out <= 1'b0;
            window_last_out  <= 1'b0;
            window_data_out  <= '0;
        end else begin
            cfg_err          <= (state == S_IDLE) && start && !cfg_ok;
            window_valid_out <= accept && win_hit;
            window_last_out  <= accept && frame_last;
            if (accept && win_hit)
                window_data_out <= win_next;
            if (start_ok) begin
                img_w <= cfg_img_width;
                img_h <= cfg_img_height;
                col   <= '0;
                row   <= '0;
            end else if (accept) begin
                if (col_last) begin
                    col <= '0;
                    row <= row + DIM_WIDTH'(1);
                end else begin
                    col <= col + DIM_WIDTH'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_window_gen
// Function : randomized self-checking bench with a pixel-index reference model.
// Revision : 1.0
// ============================================================================
module tb_conv_window_gen;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [8:0]  cfg_img_width = '0;
    logic [8:0]  cfg_img_height = '0;
    logic        start = 1'b0;
    logic        busy, done, cfg_err;
    logic [7:0]  pix_in = '0;
    logic        pix_valid_in = 1'b0;
    logic        pix_ready_out;
    logic [71:0] window_data_out;
    logic        window_valid_out, window_last_out;

    conv_window_gen dut (
        .clk              (clk),
        .rstn             (rstn),
        .cfg_img_width    (cfg_img_width),
        .cfg_img_height   (cfg_img_height),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .cfg_err          (cfg_err),
        .pix_in           (pix_in),
        .pix_valid_in     (pix_valid_in),
        .pix_ready_out    (pix_ready_out),
        .window_data_out  (window_data_out),
        .window_valid_out (window_valid_out),
        .window_last_out  (window_last_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: frame progress tracked as a count of accepted pixels.
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
    int          m_state = M_IDLE;
    int          m_cnt, m_w, m_h, m_r, m_c;
    logic [7:0]  img [0:1023];
    logic        e_valid = 1'b0, e_last = 1'b0, e_err = 1'b0;
    logic [71:0] e_data = '0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_state = M_IDLE;
            m_cnt   = 0;
            e_valid = 1'b0;
            e_last  = 1'b0;
            e_err   = 1'b0;
            e_data  = '0;
        end else begin
            e_valid = 1'b0;
            e_last  = 1'b0;
            e_err   = 1'b0;
            case (m_state)
                M_IDLE: if (start) begin
                    if (cfg_img_width >= 3 && cfg_img_width <= 256 && cfg_img_height >= 3) begin
                        m_w     = int'(cfg_img_width);
                        m_h     = int'(cfg_img_height);
                        m_cnt   = 0;
                        m_state = M_RUN;
                    end else begin
                        e_err = 1'b1;
                    end
                end
                M_RUN: if (pix_valid_in) begin
                    img[m_cnt % 1024] = pix_in;
                    m_r = m_cnt / m_w;
                    m_c = m_cnt % m_w;
                    if (m_r >= 2 && m_c >= 2) begin
                        e_valid = 1'b1;
                        for (int i = 0; i < 3; i++)
                            for (int j = 0; j < 3; j++)
                                e_data[(i*3+j)*8 +: 8] = img[((m_r-2+i)*m_w + m_c-2+j) % 1024];
                    end
                    if (m_cnt == m_w*m_h - 1) begin
                        e_last  = 1'b1;
                        m_state = M_DONE;
                    end
                    m_cnt++;
                end
                default: m_state = M_IDLE;
            endcase
        end
    end

    logic [71:0] win_q [$];

    always @(negedge clk) begin
        check("busy",  busy,             m_state == M_RUN);
        check("ready", pix_ready_out,    m_state == M_RUN);
        check("done",  done,             m_state == M_DONE);
        check("err",   cfg_err,          e_err);
        check("valid", window_valid_out, e_valid);
        check("last",  window_last_out,  e_last);
        check("data",  window_data_out,  e_data);
        if (window_last_out) check("last_with_done", done, 1'b1);
        if (window_valid_out) win_q.push_back(window_data_out);
    end

    function automatic logic [71:0] pack9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        int v [9];
        logic [71:0] w;
        v = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(v[k]);
        return w;
    endfunction

    function automatic logic [7:0] lane(input logic [71:0] w, input int k);
        return w[k*8 +: 8];
    endfunction

    function automatic logic [7:0] pixval(input int mode, input int k, input int w);
        case (mode)
            0:       return 8'(k);
            1:       return 8'(k + 100);
            2:       return 8'((k % w) - 128);
            3:       return 8'(k + 50);
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int w, input int h);
        cfg_img_width  = 9'(w);
        cfg_img_height = 9'(h);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int w, input int n, input int mode, input int gap);
        int k = 0;
        while (k < n) begin
            if (int'($urandom_range(99)) < gap) begin
                pix_valid_in = 1'b0;
                pix_in       = 8'($urandom);
            end else begin
                pix_valid_in = 1'b1;
                pix_in       = pixval(mode, k, w);
                k++;
            end
            tick();
        end
        pix_valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        idle(3);
        rstn = 1'b1;
        idle(2);

        // Basic 4x4 frame, continuous valid
        win_q.delete();
        do_start(4, 4);
        send(4, 16, 0, 0);
        idle(3);
        check("basic_count", 72'(win_q.size()), 72'd4);
        check("basic_first", win_q[0], pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
        check("basic_last",  win_q[3], pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));

        // Random valid gaps
        win_q.delete();
        do_start(5, 3);
        send(5, 15, 1, 50);
        idle(3);
        check("gap_count", 72'(win_q.size()), 72'd3);
        check("gap_first", win_q[0], pack9(100, 101, 102, 105, 106, 107, 110, 111, 112));
        check("gap_third", win_q[2], pack9(102, 103, 104, 107, 108, 109, 112, 113, 114));

        // Maximum width, signed data
        win_q.delete();
        do_start(256, 3);
        send(256, 768, 2, 10);
        idle(3);
        check("maxw_count", 72'(win_q.size()), 72'd254);
        for (int r = 0; r < 3; r++) begin
            check("maxw_first_lane", lane(win_q[0], r*3), 8'h80);
            check("maxw_last_lane",  lane(win_q[253], r*3 + 2), 8'h7F);
        end

        // Illegal configurations; offered pixels must be dropped
        win_q.delete();
        do_start(2, 5);
        send(4, 8, 4, 0);
        do_start(257, 3);
        send(4, 8, 4, 0);
        do_start(3, 2);
        send(4, 8, 4, 0);
        idle(2);
        check("illegal_windows", 72'(win_q.size()), 72'd0);

        // Reset in the middle of a frame
        do_start(4, 4);
        send(4, 10, 0, 0);
        rstn = 1'b0;
        #1;
        check("rst_busy",  busy, 1'b0);
        check("rst_valid", window_valid_out, 1'b0);
        check("rst_data",  window_data_out, 72'd0);
        idle(2);
        rstn = 1'b1;
        idle(2);
        win_q.delete();
        do_start(4, 4);
        send(4, 16, 3, 20);
        idle(3);
        check("rst_count", 72'(win_q.size()), 72'd4);
        check("rst_first", win_q[0], pack9(50, 51, 52, 54, 55, 56, 58, 59, 60));

        // Back-to-back frames: start during DONE ignored, next cycle accepted
        do_start(3, 3);
        send(3, 9, 4, 0);
        do_start(2, 3);
        win_q.delete();
        do_start(3, 3);
        send(3, 9, 4, 30);
        idle(3);
        check("b2b_count", 72'(win_q.size()), 72'd1);

        // Random frames
        for (int f = 0; f < 4; f++) begin
            int w = int'($urandom_range(3, 9));
            int h = int'($urandom_range(3, 6));
            win_q.delete();
            do_start(w, h);
            send(w, w*h, 4, int'($urandom_range(0, 60)));
            idle(3);
            check("rand_count", 72'(win_q.size()), 72'((w-2)*(h-2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Streaming 3x3 sliding-window generator that sits directly upstream of the NPU MAC core.
- Accepts a raster-order stream of 8-bit feature-map pixels for one input channel, buffers two full lines, and emits one 9-pixel window per output position.
- Output geometry is stride 1, no padding.
- The 72-bit window feeds the MAC data input (9 lanes x 8 bits) together with its valid strobe.

Parameters:
- DATA_WIDTH, 8: pixel width in bits.
- KERNEL_SIZE, 3: window edge. Fixed at 3; the design need not support other values.
- MAX_IMG_WIDTH, 256: maximum line length; sets line-buffer depth.
- DIM_WIDTH, 9: width of the dimension and counter fields. Must satisfy 2^DIM_WIDTH > MAX_IMG_WIDTH.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- cfg_img_width  input  DIM_WIDTH  image width W in pixels; sampled on accepted start.
- cfg_img_height  input  DIM_WIDTH  image height H in lines; sampled on accepted start.
- start  input  1  single-cycle frame start request.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse after the last pixel of the frame is processed.
- cfg_err  output  1  one-cycle pulse when start is rejected.
- pix_in  input  DATA_WIDTH  pixel data, two's complement, raster order.
- pix_valid_in  input  1  pixel qualifier.
- pix_ready_out  output  1  block accepts a pixel this cycle; equals busy.
- window_data_out  output  KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH  window pixels (72 bits at defaults).
- window_valid_out  output  1  window qualifier; one-cycle pulse per window.
- window_last_out  output  1  high with the final window of the frame.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Line-buffer contents are not cleared; validity is gated by the counters.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start when 3<=W<=MAX_IMG_WIDTH and 3<=H. W and H are latched, row/col counters cleared, busy=1 from the next cycle.
  - IDLE on start with illegal W or H: cfg_err pulses the next cycle; remain IDLE.
  - RUN -> DONE on acceptance of pixel (row H-1, col W-1).
  - DONE -> IDLE unconditionally after one cycle. done=1 for exactly that cycle; busy=0 in DONE.
  - start in RUN or DONE is ignored and produces no cfg_err.
- Acceptance: a pixel is accepted when pix_valid_in && pix_ready_out. Pixels offered in IDLE or DONE are dropped.
- Gaps: cycles without an accepted pixel freeze all counters, shift registers and line buffers.
- Counters: col counts 0..W-1; on W-1 it wraps to 0 and row increments.
- Line buffers: two MAX_IMG_WIDTH-deep buffers indexed by col. On accept:
  - lb1[col] <= lb0[col];
  - lb0[col] <= pix_in.
  - Reads occur before writes, so column col yields rows r-2, r-1 and the current pixel r.
- Window registers: a 3x3 register array shifts left by one column on every accept; the new right column is {lb1[col], lb0[col], pix_in}.
- Lane mapping: window_data_out[k*DATA_WIDTH +: DATA_WIDTH] holds lane k = r*3 + c.
  - r=0 is the top (oldest) row; c=0 is the leftmost (oldest) column.
  - Lane k drives MAC input lane k.
- Valid generation: when the accepted pixel has row>=2 and col>=2, window_valid_out=1 on the next cycle, with window_data_out carrying the window whose bottom-right pixel is that pixel. Latency: 1 cycle from accept to window.
- Hold: window_data_out holds its last value when not valid.
- Row wrap: windows never straddle a line boundary, because col>=2 gating discards the stale left columns after the wrap.
- window_last_out = window_valid_out for the window from pixel (H-1, W-1). It coincides with the DONE-state cycle (done=1).
- Window count per frame: exactly (W-2)*(H-2).
- Reset mid-frame: immediate return to IDLE with all outputs 0. The next frame needs a fresh start; no stale window is ever emitted.
- Arithmetic: data is pass-through, with no sign or width change.

Test Plan:
- Basic frame: start, W=4, H=4, pixels 0..15 with continuous valid.
  - Exactly 4 windows.
  - First window appears the cycle after pixel 10 is accepted, with lanes 0..8 = {0,1,2,4,5,6,8,9,10}.
  - Last window = {5,6,7,9,10,11,13,14,15} with window_last_out=1 and done=1 in the same cycle.
- Valid gaps: W=5, H=3, pixel k=k+100, pix_valid_in deasserted randomly 50% of cycles.
  - Exactly 3 windows: {100,101,102,105,106,107,110,111,112}, then the next two columns.
  - Each window arrives 1 cycle after its completing pixel.
- Max width, signed data: W=256, H=3, pixel = col-128 cast to 8 bits.
  - 254 windows.
  - Window 0 lanes 0,3,6 = -128 (0x80); window 253 lanes 2,5,8 = 127 (0x7F).
- Illegal config:
  - start with W=2, H=5 -> cfg_err pulse, busy stays 0, all pixels dropped.
  - start with W=257 -> same.
- Reset mid-frame: W=4, H=4, assert rstn low after pixel 9.
  - Outputs 0 immediately, state IDLE.
  - A new start with pixels 50..65 yields a first window {50,51,52,54,55,56,58,59,60}.
- Back-to-back frames: start asserted during DONE is ignored; start the cycle after DONE is accepted.
  - The second 3x3 frame yields exactly 1 window.
